// File: rtl/cu_multicycle_ctrl_if.sv
// Control bus between the multi-cycle MIPS control unit and its datapath:
// opcode and memory/halt handshake in, datapath strobes and status out.
interface cu_multicycle_ctrl_if #(
    parameter int OPW = 6
);
    logic [OPW-1:0] Opcode;
    logic           MEM_READY;
    logic           HALT;

    logic           PCWrite;
    logic           Branch;
    logic           BranchNE;
    logic           IorD;
    logic           MemRead;
    logic           MemWrite;
    logic           IRWrite;
    logic           MemtoReg;
    logic           RegDst;
    logic           RegWrite;
    logic           ALUSrcA;
    logic [1:0]     ALUSrcB;
    logic [1:0]     ALUOp;
    logic [1:0]     PCSrc;

    logic [3:0]     STATE;
    logic           INSTR_DONE;
    logic           ILLEGAL;
    logic           HALTED;

    // The control unit drives the strobes.
    modport master (
        input  Opcode, MEM_READY, HALT,
        output PCWrite, Branch, BranchNE, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
               STATE, INSTR_DONE, ILLEGAL, HALTED
    );

    // The datapath and memory side drive the opcode and handshake.
    modport slave (
        output Opcode, MEM_READY, HALT,
        input  PCWrite, Branch, BranchNE, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
               STATE, INSTR_DONE, ILLEGAL, HALTED
    );
endinterface

// File: rtl/cu_multicycle_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing each instruction over
// 3-5 cycles, with memory-ready wait states, halt request and illegal-opcode pulse.
module cu_multicycle_ctrl #(
    parameter int OPW        = 6,
    parameter bit ENABLE_BNE = 1'b1
) (
    input logic                  CLK,
    input logic                  RST_N,
    cu_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        HALTST = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        KIND_ILLEGAL,
        KIND_LW,
        KIND_SW,
        KIND_RTYPE,
        KIND_BEQ,
        KIND_BNE,
        KIND_ADDI,
        KIND_J
    } kind_t;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal;
        logic       halted;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] PCSRC_ALU   = 2'b00;
    localparam logic [1:0] PCSRC_OUT   = 2'b01;
    localparam logic [1:0] PCSRC_JUMP  = 2'b10;

    state_t state, state_nxt;
    kind_t  kind, kind_nxt, op_kind;
    ctrl_t  ctrl, ctrl_out;

    // Opcode classification; bne folds into illegal when not built in.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        op_kind = KIND_ILLEGAL;
        case (bus.Opcode)
            OP_LW:    op_kind = KIND_LW;
            OP_SW:    op_kind = KIND_SW;
            OP_RTYPE: op_kind = KIND_RTYPE;
            OP_BEQ:   op_kind = KIND_BEQ;
            OP_BNE:   op_kind = ENABLE_BNE ? KIND_BNE : KIND_ILLEGAL;
            OP_ADDI:  op_kind = KIND_ADDI;
            OP_J:     op_kind = KIND_J;
            default:  op_kind = KIND_ILLEGAL;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= FETCH;
            kind  <= KIND_ILLEGAL;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            kind  <= kind_nxt;
        end
    end

    // Next-state logic; the decoded kind is captured once in DECODE so later
    // states steer on a registered value rather than the live opcode.
    always_comb begin
        state_nxt = FETCH;
        kind_nxt  = kind;
        case (state)
            FETCH: begin
                if (bus.MEM_READY)
                    state_nxt = DECODE;
                else if (bus.HALT)
                    state_nxt = HALTST;
                else
                    state_nxt = FETCH;
            end
            HALTST: state_nxt = bus.HALT ? HALTST : FETCH;
            DECODE: begin
                kind_nxt = op_kind;
                case (op_kind)
                    KIND_LW, KIND_SW:   state_nxt = MEMADR;
                    KIND_RTYPE:         state_nxt = EXEC;
                    KIND_BEQ, KIND_BNE: state_nxt = BRANCH;
                    KIND_ADDI:          state_nxt = ADDIEX;
                    KIND_J:             state_nxt = JUMP;
                    default:            state_nxt = FETCH;
                endcase
            end
            MEMADR: state_nxt = (kind == KIND_SW) ? MEMWR : MEMRD;
            MEMRD:  state_nxt = bus.MEM_READY ? MEMWB : MEMRD;
            MEMWB:  state_nxt = FETCH;
            MEMWR:  state_nxt = bus.MEM_READY ? FETCH : MEMWR;
            EXEC:   state_nxt = ALUWB;
            ALUWB:  state_nxt = FETCH;
            BRANCH: state_nxt = FETCH;
            ADDIEX: state_nxt = ADDIWB;
            ADDIWB: state_nxt = FETCH;
            JUMP:   state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Strobe decode by state; MEM_READY gating in FETCH and MEMWR is the only
    // combinational input dependence apart from the DECODE illegal pulse.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = bus.MEM_READY;
                ctrl.pc_write  = bus.MEM_READY;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH2;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.illegal   = (op_kind == KIND_ILLEGAL);
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = bus.MEM_READY;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_src     = PCSRC_OUT;
                ctrl.branch     = (kind == KIND_BEQ);
                ctrl.branch_ne  = (kind == KIND_BNE);
                ctrl.instr_done = 1'b1;
            end
            ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            HALTST: ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

    // FETCH strobes would otherwise show while reset holds the state at FETCH.
    assign ctrl_out = RST_N ? ctrl : '0;

    assign bus.PCWrite    = ctrl_out.pc_write;
    assign bus.Branch     = ctrl_out.branch;
    assign bus.BranchNE   = ctrl_out.branch_ne;
    assign bus.IorD       = ctrl_out.iord;
    assign bus.MemRead    = ctrl_out.mem_read;
    assign bus.MemWrite   = ctrl_out.mem_write;
    assign bus.IRWrite    = ctrl_out.ir_write;
    assign bus.MemtoReg   = ctrl_out.mem_to_reg;
    assign bus.RegDst     = ctrl_out.reg_dst;
    assign bus.RegWrite   = ctrl_out.reg_write;
    assign bus.ALUSrcA    = ctrl_out.alu_src_a;
    assign bus.ALUSrcB    = ctrl_out.alu_src_b;
    assign bus.ALUOp      = ctrl_out.alu_op;
    assign bus.PCSrc      = ctrl_out.pc_src;
    assign bus.INSTR_DONE = ctrl_out.instr_done;
    assign bus.ILLEGAL    = ctrl_out.illegal;
    assign bus.HALTED     = ctrl_out.halted;
    assign bus.STATE      = state;

    a_rd_wr_excl: assert property (@(posedge CLK) disable iff (!RST_N)
        !(bus.MemRead && bus.MemWrite));
    a_reg_mem_excl: assert property (@(posedge CLK) disable iff (!RST_N)
        !(bus.RegWrite && bus.MemWrite));
    a_halted_state: assert property (@(posedge CLK) disable iff (!RST_N)
        bus.HALTED == (state == HALTST));

endmodule

// File: tb/tb_cu_multicycle_ctrl.sv
// Scoreboarded bench for cu_multicycle_ctrl: expected output vectors are queued
// per cycle as stimulus is driven and compared on the following falling edge.
module tb_cu_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC  = 4'd6,  S_ALUWB  = 4'd7,  S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JUMP   = 4'd11;
    localparam logic [3:0] S_HALT  = 4'd12;

    typedef struct {
        string       tag;
        logic [23:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    cu_multicycle_ctrl_if #(.OPW(6)) bus ();
    cu_multicycle_ctrl_if #(.OPW(6)) bus_b ();

    assign bus_b.Opcode    = bus.Opcode;
    assign bus_b.MEM_READY = bus.MEM_READY;
    assign bus_b.HALT      = bus.HALT;

    cu_multicycle_ctrl #(.OPW(6), .ENABLE_BNE(1'b0)) dut (
        .CLK(clk), .RST_N(rst_n), .bus(bus)
    );

    cu_multicycle_ctrl #(.OPW(6), .ENABLE_BNE(1'b1)) dut_b (
        .CLK(clk), .RST_N(rst_n), .bus(bus_b)
    );

    // {strobes[10:0], ALUSrcB, ALUOp, PCSrc, STATE, INSTR_DONE, ILLEGAL, HALTED}
    logic [23:0] act, act_b;
    assign act = {bus.PCWrite, bus.Branch, bus.BranchNE, bus.IorD, bus.MemRead,
                  bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc, bus.STATE,
                  bus.INSTR_DONE, bus.ILLEGAL, bus.HALTED};
    assign act_b = {bus_b.PCWrite, bus_b.Branch, bus_b.BranchNE, bus_b.IorD, bus_b.MemRead,
                    bus_b.MemWrite, bus_b.IRWrite, bus_b.MemtoReg, bus_b.RegDst, bus_b.RegWrite,
                    bus_b.ALUSrcA, bus_b.ALUSrcB, bus_b.ALUOp, bus_b.PCSrc, bus_b.STATE,
                    bus_b.INSTR_DONE, bus_b.ILLEGAL, bus_b.HALTED};

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %06h, want %06h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Expected outputs for one cycle in a given state, from the control table.
    function automatic logic [23:0] ev(input logic [3:0] st, input bit rdy,
                                       input bit ill, input bit is_bne);
        logic pcw, br, brne, iord, mr, mw, irw, m2r, rd, rw, sa, dn, hl;
        logic [1:0] sb, ao, ps;
        {pcw, br, brne, iord, mr, mw, irw, m2r, rd, rw, sa, dn, hl} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            S_FETCH:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE: sb = 2'b11;
            S_MEMADR: begin sa = 1; sb = 2'b10; end
            S_MEMRD:  begin mr = 1; iord = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; dn = 1; end
            S_MEMWR:  begin mw = 1; iord = 1; dn = rdy; end
            S_EXEC:   begin sa = 1; ao = 2'b10; end
            S_ALUWB:  begin rw = 1; rd = 1; dn = 1; end
            S_BRANCH: begin sa = 1; ao = 2'b01; ps = 2'b01; dn = 1; br = !is_bne; brne = is_bne; end
            S_ADDIEX: begin sa = 1; sb = 2'b10; end
            S_ADDIWB: begin rw = 1; dn = 1; end
            S_JUMP:   begin pcw = 1; ps = 2'b10; dn = 1; end
            S_HALT:   hl = 1;
            default:  ;
        endcase
        return {pcw, br, brne, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, st, dn, ill, hl};
    endfunction

    task automatic push_b(input string tag, input logic [3:0] st, input bit rdy, input bit is_bne);
        exp_t e;
        e.tag = tag;
        e.v   = ev(st, rdy, 1'b0, is_bne);
        qb.push_back(e);
    endtask

    // Drive one cycle's inputs, queue its expected outputs, advance to just past the edge.
    task automatic step(input string tag, input logic [3:0] st, input logic [5:0] op,
                        input bit rdy, input bit hlt, input bit ill = 1'b0);
        exp_t e;
        bus.Opcode    = op;
        bus.MEM_READY = rdy;
        bus.HALT      = hlt;
        e.tag = tag;
        e.v   = ev(st, rdy, ill, 1'b0);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check(e.tag, act, e.v);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check(e.tag, act_b, e.v);
        end
        if (rst_n) begin
            check("excl_rd_wr", 24'(bus.MemRead & bus.MemWrite), 24'(0));
            check("excl_reg_mem", 24'(bus.RegWrite & bus.MemWrite), 24'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Opcode    = OP_R;
        bus.MEM_READY = 1'b0;
        bus.HALT      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", act, 24'(0));
        rst_n = 1'b1;

        // R-type, memory always ready: 0,1,6,7
        step("r_fetch",  S_FETCH,  OP_R, 1, 0);
        step("r_decode", S_DECODE, OP_R, 1, 0);
        step("r_exec",   S_EXEC,   OP_R, 1, 0);
        step("r_aluwb",  S_ALUWB,  OP_R, 1, 0);

        // lw with two MEMRD wait states: 7 cycles; MEM_READY low is ignored in DECODE/MEMADR
        step("lw_fetch",  S_FETCH,  OP_LW, 1, 0);
        step("lw_decode", S_DECODE, OP_LW, 0, 0);
        step("lw_memadr", S_MEMADR, OP_LW, 0, 0);
        step("lw_memrd0", S_MEMRD,  OP_LW, 0, 0);
        step("lw_memrd1", S_MEMRD,  OP_LW, 0, 0);
        step("lw_memrd2", S_MEMRD,  OP_LW, 1, 0);
        step("lw_memwb",  S_MEMWB,  OP_LW, 0, 0);

        // sw with a fetch wait and two MEMWR waits
        step("sw_fetchw", S_FETCH,  OP_SW, 0, 0);
        step("sw_fetch",  S_FETCH,  OP_SW, 1, 0);
        step("sw_decode", S_DECODE, OP_SW, 1, 0);
        step("sw_memadr", S_MEMADR, OP_SW, 1, 0);
        step("sw_memwr0", S_MEMWR,  OP_SW, 0, 0);
        step("sw_memwr1", S_MEMWR,  OP_SW, 0, 0);
        step("sw_memwr2", S_MEMWR,  OP_SW, 1, 0);

        // beq
        step("beq_fetch",  S_FETCH,  OP_BEQ, 1, 0);
        step("beq_decode", S_DECODE, OP_BEQ, 1, 0);
        step("beq_branch", S_BRANCH, OP_BEQ, 1, 0);

        // bne: illegal on the main instance, a branch on the bne-enabled one
        push_b("bneb_fetch", S_FETCH, 1, 1'b0);
        step("bne_fetch",  S_FETCH,  OP_BNE, 1, 0);
        push_b("bneb_decode", S_DECODE, 1, 1'b0);
        step("bne_illegal", S_DECODE, OP_BNE, 1, 0, 1'b1);
        push_b("bneb_branch", S_BRANCH, 0, 1'b1);
        step("bne_refetch", S_FETCH, OP_BNE, 0, 0);
        push_b("bneb_refetch", S_FETCH, 0, 1'b0);
        step("bne_refetch2", S_FETCH, OP_BNE, 0, 0);

        // Unsupported opcode
        step("bad_fetch",  S_FETCH,  OP_BAD, 1, 0);
        step("bad_decode", S_DECODE, OP_BAD, 1, 0, 1'b1);

        // Halt while memory busy, resume, then j with HALT ignored under MEM_READY
        step("halt_req",   S_FETCH, OP_J, 0, 1);
        step("halted0",    S_HALT,  OP_J, 0, 1);
        step("halted1",    S_HALT,  OP_J, 1, 1);
        step("halt_rel",   S_HALT,  OP_J, 0, 0);
        step("j_fetch",    S_FETCH, OP_J, 1, 1);
        step("j_decode",   S_DECODE, OP_J, 1, 0);
        step("j_jump",     S_JUMP,  OP_J, 1, 0);

        // addi, full
        step("addi_fetch",  S_FETCH,  OP_ADDI, 1, 0);
        step("addi_decode", S_DECODE, OP_ADDI, 1, 0);
        step("addi_ex",     S_ADDIEX, OP_ADDI, 1, 0);
        step("addi_wb",     S_ADDIWB, OP_ADDI, 1, 0);

        // addi interrupted by reset in ADDIEX
        step("rst_fetch",  S_FETCH,  OP_ADDI, 1, 0);
        step("rst_decode", S_DECODE, OP_ADDI, 1, 0);
        #1;
        check("rst_pre_addiex", act, ev(S_ADDIEX, 1, 1'b0, 1'b0));
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", act, 24'(0));
        check("rst_async_clear_b", act_b, 24'(0));
        @(posedge clk);
        #1;
        check("rst_held", act, 24'(0));
        rst_n = 1'b1;
        check("post_rst_state", 24'(bus.STATE), 24'(S_FETCH));

        step("post_fetch",  S_FETCH,  OP_R, 1, 0);
        step("post_decode", S_DECODE, OP_R, 1, 0);
        step("post_exec",   S_EXEC,   OP_R, 1, 0);
        step("post_aluwb",  S_ALUWB,  OP_R, 1, 0);

        @(negedge clk);
        #1;
        check("sb_drain", 24'(q.size() + qb.size()), 24'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cu_multicycle_ctrl.md
# cu_multicycle_ctrl

Multi-cycle MIPS control unit: a Moore state machine that sequences each instruction over 3–5 cycles and drives the shared-datapath control strobes. It replaces the single-cycle main decoder in the multi-cycle core variant and sits between the instruction register opcode field and the datapath multiplexers and enables. It adds a memory-ready handshake for slow memories, an optional `bne`, a halt request and illegal-opcode reporting.

## Interface
- `OPW`, 6, opcode width.
- `ENABLE_BNE`, 1, when 1, decode opcode 6'b000101 as `bne`; when 0, treat it as illegal.
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `Opcode` in OPW: IR[31:26], valid from DECODE onward.
- `MEM_READY` in 1: memory completed the current access this cycle.
- `HALT` in 1: sampled in FETCH; request to stop issuing.
- `PCWrite`, `Branch`, `BranchNE`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA` out 1: datapath strobes.
- `ALUSrcB` out 2: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `ALUOp` out 2: 00 = add, 01 = sub, 10 = funct field.
- `PCSrc` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `STATE` out 4: current state encoding, for debug.
- `INSTR_DONE` out 1: one-cycle pulse in the final state of each instruction.
- `ILLEGAL` out 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `HALTED` out 1: high while in HALTST.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, HALTST 12. Unused encodings go to FETCH on the next edge.
- All outputs are decoded only from state (Moore), except that the `MEM_READY` gating below is combinational. Every strobe not listed for a state is 0, `ALUSrcB`, `ALUOp` and `PCSrc` default to 00, and `ALUSrcA` defaults to 0.
- Reset: async entry to FETCH. During reset all outputs are 0, `STATE` = 0 and the pulse outputs are 0.
- FETCH:
  - Outputs: `MemRead` = 1, `IorD` = 0, `ALUSrcB` = 01, `ALUOp` = 00, `PCSrc` = 00.
  - `IRWrite` and `PCWrite` are asserted only when `MEM_READY` = 1. Advance to DECODE on `MEM_READY`; otherwise stay.
  - If `HALT` = 1 on entry-cycle evaluation and `MEM_READY` = 0, go to HALTST. `HALT` is ignored once `MEM_READY` = 1 in the same cycle, so a fetch never completes half-way.
- HALTST: all strobes 0. Return to FETCH when `HALT` = 0.
- DECODE: `ALUSrcB` = 11, `ALUOp` = 00 (branch-target precompute). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXEC.
  - 000100 (beq), or 000101 (bne) with `ENABLE_BNE` = 1 → BRANCH.
  - 001000 (addi) → ADDIEX.
  - 000010 (j) → JUMP.
  - Any other opcode: pulse `ILLEGAL` and go to FETCH. No register or memory write occurs.
- MEMADR: `ALUSrcA` = 1, `ALUSrcB` = 10. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `MemRead` = 1, `IorD` = 1. Stay until `MEM_READY`, then go to MEMWB.
- MEMWB: `RegWrite` = 1, `MemtoReg` = 1, `RegDst` = 0, `INSTR_DONE`. Then FETCH.
- MEMWR: `MemWrite` = 1, `IorD` = 1. Stay until `MEM_READY`. `INSTR_DONE` pulses in the cycle `MEM_READY` = 1, then FETCH.
- EXEC: `ALUSrcA` = 1, `ALUSrcB` = 00, `ALUOp` = 10. Then ALUWB.
- ALUWB: `RegWrite` = 1, `RegDst` = 1, `INSTR_DONE`. Then FETCH.
- BRANCH: `ALUSrcA` = 1, `ALUOp` = 01, `PCSrc` = 01, `INSTR_DONE`. `Branch` = 1 for beq; `BranchNE` = 1 for bne. Then FETCH.
- ADDIEX: `ALUSrcA` = 1, `ALUSrcB` = 10, `ALUOp` = 00. Then ADDIWB.
- ADDIWB: `RegWrite` = 1, `RegDst` = 0, `MemtoReg` = 0, `INSTR_DONE`. Then FETCH.
- JUMP: `PCWrite` = 1, `PCSrc` = 10, `INSTR_DONE`. Then FETCH.
- Strobe exclusivity: `MemWrite` and `MemRead` are never both 1. `RegWrite` and `MemWrite` are never both 1.

## Timing
- Cycles per instruction with `MEM_READY` tied high: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- Each cycle `MEM_READY` is low in FETCH, MEMRD or MEMWR adds exactly one cycle. `MEM_READY` is ignored in every other state.
- `Opcode` must be stable from DECODE to instruction end; the IR is written only in FETCH.
- Reset asserted mid-instruction: outputs clear within the same cycle (asynchronous). No write strobe glitches high. After deassertion, the first rising edge evaluates FETCH.

## Test plan
- Reset then `MEM_READY` = 1, opcode 000000: `STATE` sequence 0,1,6,7,0; `RegWrite` & `RegDst` = 1 only in state 7; `INSTR_DONE` pulses once.
- lw (100011) with `MEM_READY` low for 2 cycles in MEMRD: 7 cycles total; `MemtoReg` = 1 only in MEMWB; `IorD` = 1 throughout MEMRD.
- sw (101011): `MemWrite` held through the wait states; `RegWrite` never 1; `INSTR_DONE` coincides with `MEM_READY`.
- beq, then bne with `ENABLE_BNE` = 0: beq gives `Branch` = 1 and `PCSrc` = 01 in state 8; bne gives an `ILLEGAL` pulse and a return to FETCH with no strobes.
- `HALT` = 1 in FETCH with `MEM_READY` = 0: `HALTED` = 1 and state 12. Deassert `HALT`: FETCH resumes. Then a j instruction: `PCWrite` = 1 and `PCSrc` = 10 in state 11.
- Assert `RST_N` = 0 during ADDIEX: all outputs drop to 0 immediately; after release, `STATE` = 0.
